// File: rtl/ssd_scan.sv
// ssd_scan: time-multiplexed driver for the eight-digit seven-segment display.
// Each frame is shown from one snapshot of ssds/blank/dp that is taken when
// digit 0 turns on. A guard gap with all anodes off separates every two digits.
module ssd_scan #(
  parameter logic [15:0] DIGIT_CYCLES     = 16'd50000,
  parameter logic [15:0] GUARD_CYCLES     = 16'd500,
  parameter logic [15:0] SIM_DIGIT_CYCLES = 16'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_sim,
  input  logic [31:0] ssds,
  input  logic [7:0]  blank,
  input  logic [7:0]  dp,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_start
);

  typedef enum logic {GUARD, ON} state_t;

  state_t      state;
  logic [2:0]  dig;
  logic [15:0] cnt;
  logic [31:0] snap_ssds;
  logic [7:0]  snap_blank;
  logic [7:0]  snap_dp;

  logic [15:0] g_last, d_last;
  logic        guard_done, on_done, cap, show_on;
  logic [31:0] src_ssds;
  logic [7:0]  src_blank, src_dp;
  logic [3:0]  nib;
  logic        dig_blank, dig_dp;
  logic [7:0]  on_an;
  logic [6:0]  on_seg;
  logic        on_dpn;

  // Active-low {g,f,e,d,c,b,a} hex decode.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Thresholds, state-exit conditions and the next-cycle ON output values.
  // On the edge that captures the snapshot, digit 0 decodes from the live
  // inputs so the captured value and the displayed value are the same word.
  always_comb begin
    g_last     = in_sim ? 16'd0 : GUARD_CYCLES - 16'd1;
    d_last     = (in_sim ? SIM_DIGIT_CYCLES : DIGIT_CYCLES) - 16'd1;
    guard_done = (state == GUARD) && (cnt == g_last);
    on_done    = (state == ON) && (cnt == d_last);
    cap        = guard_done && (dig == 3'd0);
    show_on    = guard_done || ((state == ON) && !on_done);
    src_ssds   = cap ? ssds  : snap_ssds;
    src_blank  = cap ? blank : snap_blank;
    src_dp     = cap ? dp    : snap_dp;
    nib        = src_ssds[{dig, 2'b00} +: 4];
    dig_blank  = src_blank[dig];
    dig_dp     = src_dp[dig];
    on_an      = dig_blank ? 8'hFF : ~(8'b1 << dig);
    on_seg     = dig_blank ? 7'h7F : seg_decode(nib);
    on_dpn     = dig_blank | ~dig_dp;
  end

  // Scan FSM, counters, snapshot and registered pin outputs share one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= GUARD;
      dig         <= 3'd0;
      cnt         <= 16'd0;
      snap_ssds   <= 32'd0;
      snap_blank  <= 8'd0;
      snap_dp     <= 8'd0;
      an          <= 8'hFF;
      seg         <= 7'h7F;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= cap;
      if (cap) begin
        snap_ssds  <= ssds;
        snap_blank <= blank;
        snap_dp    <= dp;
      end
      if (show_on) begin
        an   <= on_an;
        seg  <= on_seg;
        dp_n <= on_dpn;
      end else begin
        an   <= 8'hFF;
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end
      case (state)
        GUARD: begin
          if (guard_done) begin
            state <= ON;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          // A threshold that shrinks under cnt lets cnt wrap through 16 bits.
          if (on_done) begin
            state <= GUARD;
            cnt   <= 16'd0;
            dig   <= dig + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_scan.sv
// tb_ssd_scan: table-driven frame checks for ssd_scan in sim timing, plus
// hand-written sequences for mid-frame reset and the long-timing instance.
module tb_ssd_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_sim;
  logic        in_sim2;
  logic [31:0] ssds;
  logic [7:0]  blank, dp;
  logic [7:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp_n, dpn2, fs, fs2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ssd_scan dut (
    .clk(clk), .rst(rst), .in_sim(in_sim), .ssds(ssds), .blank(blank), .dp(dp),
    .an(an), .seg(seg), .dp_n(dp_n), .frame_start(fs)
  );

  ssd_scan #(.DIGIT_CYCLES(16'd10), .GUARD_CYCLES(16'd3)) dut2 (
    .clk(clk), .rst(rst), .in_sim(in_sim2), .ssds(ssds), .blank(blank), .dp(dp),
    .an(an2), .seg(seg2), .dp_n(dpn2), .frame_start(fs2)
  );

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
    S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010,
    S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000,
    SB = 7'b0000011, SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110,
    SF = 7'b0001110, SX = 7'h7F;

  typedef struct {
    logic [31:0]     ssds;
    logic [7:0]      blank;
    logic [7:0]      dp;
    logic            mid_en;    // rewrite ssds while digit 3 is on
    logic [31:0]     mid_ssds;
    logic [7:0][6:0] seg;       // expected seg per digit, [7] first in literal
  } vec_t;

  vec_t vt[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s digit %0d: got %h want %h", nm, d, act, exp);
    end
  endtask

  // Apply one vector's inputs and check a whole 40-cycle frame, starting
  // from the guard slot that precedes digit 0.
  task automatic check_frame(input vec_t v);
    logic [7:0] one;
    logic [7:0] e_an;
    logic       e_dpn;
    one   = 8'b1;
    ssds  = v.ssds;
    blank = v.blank;
    dp    = v.dp;
    for (int d = 0; d < 8; d++) begin
      e_an  = v.blank[d] ? 8'hFF : ~(one << d);
      e_dpn = v.blank[d] | ~v.dp[d];
      for (int c = 0; c < 4; c++) begin
        step();
        if (v.mid_en && d == 3 && c == 0) ssds = v.mid_ssds;
        chk("an_on", d, 32'(an), 32'(e_an));
        chk("seg_on", d, 32'(seg), 32'(v.seg[d]));
        chk("dpn_on", d, 32'(dp_n), 32'(e_dpn));
        chk("frame_start", d, 32'(fs), 32'((d == 0 && c == 0) ? 1 : 0));
      end
      step();
      chk("an_guard", d, 32'(an), 32'hFF);
      chk("seg_guard", d, 32'(seg), 32'h7F);
      chk("dpn_guard", d, 32'(dp_n), 32'h1);
    end
  endtask

  logic [7:0] tr_an[300];
  logic       tr_fs[300];

  initial begin
    int f1, f2, run_on, run_off, k;

    vt[0] = '{32'h0123ABCD, 8'h00, 8'h00, 1'b0, 32'h0,
              {S0, S1, S2, S3, SA, SB, SC, SD}};
    vt[1] = '{32'h3210ABCD, 8'h00, 8'h00, 1'b1, 32'hFFFFFFFF,
              {S3, S2, S1, S0, SA, SB, SC, SD}};
    vt[2] = '{32'hFFFFFFFF, 8'h00, 8'h00, 1'b0, 32'h0,
              {SF, SF, SF, SF, SF, SF, SF, SF}};
    vt[3] = '{32'h0123ABCD, 8'hF0, 8'h01, 1'b0, 32'h0,
              {SX, SX, SX, SX, SA, SB, SC, SD}};
    vt[4] = '{32'h89EF4567, 8'h00, 8'hAA, 1'b0, 32'h0,
              {S8, S9, SE, SF, S4, S5, S6, S7}};

    rst     = 1'b1;
    in_sim  = 1'b1;
    in_sim2 = 1'b0;
    ssds    = 32'h0123ABCD;
    blank   = 8'h00;
    dp      = 8'h00;
    #12;
    chk("rst_an", 0, 32'(an), 32'hFF);
    chk("rst_seg", 0, 32'(seg), 32'h7F);
    chk("rst_dpn", 0, 32'(dp_n), 32'h1);
    chk("rst_fs", 0, 32'(fs), 32'h0);
    step();
    rst = 1'b0;

    // Back-to-back frames; first edge after release enters digit 0.
    for (int i = 0; i < 5; i++) check_frame(vt[i]);

    // Reset while digit 5 is on: outputs clear without a clock edge.
    ssds  = 32'h0123ABCD;
    blank = 8'h00;
    dp    = 8'h00;
    for (int i = 0; i < 26; i++) step();
    chk("pre_rst_an", 5, 32'(an), 32'hDF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", 5, 32'(an), 32'hFF);
    chk("async_rst_seg", 5, 32'(seg), 32'h7F);
    chk("async_rst_dpn", 5, 32'(dp_n), 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    check_frame(vt[0]);

    // Long-timing instance: guard 3, dwell 10, frame 104.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i < 300; i++) begin
      step();
      tr_an[i] = an2;
      tr_fs[i] = fs2;
    end
    f1 = -1;
    f2 = -1;
    for (int i = 1; i < 300; i++) begin
      if (tr_fs[i] && f1 < 0) f1 = i;
      else if (tr_fs[i] && f1 >= 0 && f2 < 0) f2 = i;
    end
    chk("slow_first_fs", 0, 32'(f1), 32'd3);
    chk("slow_frame_len", 0, 32'(f2 - f1), 32'd104);
    run_on  = 0;
    run_off = 0;
    k = (f1 > 0) ? f1 : 1;
    while (k < 299 && tr_an[k] == 8'hFE) begin run_on++;  k++; end
    while (k < 299 && tr_an[k] == 8'hFF) begin run_off++; k++; end
    chk("slow_on_len", 0, 32'(run_on), 32'd10);
    chk("slow_gap_len", 0, 32'(run_off), 32'd3);
    chk("slow_next_an", 1, 32'(tr_an[k]), 32'hFD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan.md
# ssd_scan

Time-multiplexed driver for the Nexys 4 eight-digit seven-segment display. It sits directly downstream of the COP. It consumes the COP's 32-bit `ssds` word (eight hex nibbles: memory address and read data) and drives the board's active-low anode and cathode pins. Each display frame is taken from one snapshot, so digits never tear mid-frame. A dead-time guard between digits suppresses ghosting.

## Interface
- `DIGIT_CYCLES`, default 16'd50000: ON dwell per digit in cycles when `in_sim`=0 (0.5 ms at 100 MHz); must be ≥1.
- `GUARD_CYCLES`, default 16'd500: all-anodes-off gap before each digit when `in_sim`=0; must be ≥1.
- `SIM_DIGIT_CYCLES`, default 16'd4: ON dwell when `in_sim`=1; guard is fixed at 1 cycle in sim.
- `clk` in 1: system clock; everything is on posedge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_sim` in 1: selects the short simulation timing.
- `ssds` in 32: display data; digit i shows `ssds[4i+3:4i]`; digit 0 is rightmost.
- `blank` in 8: bit i=1 keeps digit i dark.
- `dp` in 8: bit i=1 lights the decimal point of digit i.
- `an` out 8: anodes, active-low, at most one bit low.
- `seg` out 7: cathodes, active-low, ordered `{g,f,e,d,c,b,a}`.
- `dp_n` out 1: decimal-point cathode, active-low.
- `frame_start` out 1: one-cycle pulse when digit 0 enters ON.

## Operation
- The FSM has two states, GUARD and ON. It has a 3-bit digit index `dig` and a 16-bit cycle counter `cnt`, and keeps a snapshot register set `{snap_ssds, snap_blank, snap_dp}`.
- Thresholds are `G = in_sim ? 1 : GUARD_CYCLES` and `D = in_sim ? SIM_DIGIT_CYCLES : DIGIT_CYCLES`. `in_sim` is sampled every cycle. A change only affects the comparison for the current state; there is no restart.
- GUARD: `cnt` increments. When `cnt == G-1`, the FSM moves to ON, `cnt` clears to 0, and `dig` is unchanged.
- ON: `cnt` increments. When `cnt == D-1`, the FSM moves to GUARD, `cnt` clears to 0, and `dig` becomes `dig+1` mod 8 (7 wraps to 0).
- On the GUARD→ON edge with `dig==0`:
  - the snapshot loads `ssds`, `blank` and `dp`;
  - `frame_start` is 1 for exactly that following cycle.
- All other digits of the frame use the snapshot. Input changes mid-frame are invisible until the next frame.
- Output registers are all updated on the same edge as the state.
  - Entering or staying in ON with digit i: `an = ~(8'b1 << i)` unless `blank[i]` is set, in which case `an = 8'hFF`. `seg` = decode of nibble i; `dp_n = ~dp[i]`. For digit 0, decode uses the live `ssds`/`blank`/`dp` being captured; for digits 1–7 it uses the snapshot.
  - In GUARD: `an = 8'hFF`, `seg = 7'h7F`, `dp_n = 1`.
  - A blanked digit also forces `seg = 7'h7F` and `dp_n = 1`.
- Decode values (active-low `{g..a}`):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110

## Timing
- Reset (async, immediate):
  - state GUARD, `dig` = 0, `cnt` = 0, snapshot = 0;
  - `an` = 8'hFF, `seg` = 7'h7F, `dp_n` = 1, `frame_start` = 0.
- Frame length is `8*(G+D)` cycles. With `in_sim`=1 and default parameters, that is 8*(1+4) = 40 cycles.
- After `rst` falls, the first posedge ends the 1-cycle guard (sim). At that edge `an`→FE, `frame_start`→1 and the snapshot loads.
- Each digit's `an` stays low for exactly D cycles. Consecutive digits are always separated by G cycles with `an` = FF, so there is no cycle with two anodes low.
- `rst` asserted mid-frame returns all outputs to reset values asynchronously. The sequence restarts at digit 0 with a full guard.
- If `in_sim` toggles during ON so that `cnt` already exceeds the new `D-1`, `cnt` keeps counting. It wraps at 16 bits to reach the threshold, which is acceptable and deliberate. The bench must not toggle `in_sim` mid-frame except in that scenario.

## Test plan
- Reset with `in_sim`=1 and `ssds`=32'h0123ABCD, then release. Required response:
  - first ON: `an`=FE, `seg`=0100001 (d), `frame_start` pulses once;
  - digits 1..7 follow: `an`=FD..7F, `seg` showing C, b, A, 3, 2, 1, 0;
  - `frame_start` repeats every 40 cycles.
- Every cycle, `an` is FF or has exactly one low bit. There are exactly 4 low cycles per digit and 1 FF cycle between digits.
- Change `ssds` to 32'hFFFFFFFF during digit 3 of a frame. Digits 4–7 still show 0,1,2,3 (the old snapshot). The next frame shows F on all digits (`seg`=0001110).
- `blank`=8'hF0 and `dp`=8'h01. Digits 4–7 keep `an`=FF, `seg`=7F and `dp_n`=1 during their slots. Digit 0 has `dp_n`=0, and all other digits have `dp_n`=1.
- Assert `rst` for 1 cycle while digit 5 is ON. `an` goes to FF immediately. After release, the next active digit is 0 after a 1-cycle guard.
- With `in_sim`=0, `DIGIT_CYCLES`=10 and `GUARD_CYCLES`=3 overridden: each digit has 10 low cycles and gaps are 3 cycles; the frame is 104 cycles.
